// File: rtl/spi_master_crc.sv
// SPI master for the 32-bit slave frame: 24 data bits MSB-first followed by a CRC-8
// over those bits, full duplex, with receive-side CRC checking.
module spi_master_crc #(
    parameter int                 CLK_DIV  = 2,
    parameter int                 DATA_W   = 24,
    parameter int                 CRC_W    = 8,
    parameter logic [CRC_W-1:0]   CRC_POLY = 8'h1D,
    parameter logic [CRC_W-1:0]   CRC_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic [CRC_W-1:0]  rx_crc,
    output logic              crc_err,
    output logic              sck,
    output logic              csn,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int               DIV_W     = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LAST_BIT  = 6'(DATA_W + CRC_W - 1);
    localparam logic [5:0]       LAST_DATA = 6'(DATA_W - 1);

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic [DATA_W-2:0] tx_sr;
    logic [CRC_W-1:0]  tx_crc;
    logic [DATA_W-1:0] rx_sr;
    logic [CRC_W-1:0]  rx_crc_sr;
    logic [CRC_W-1:0]  rx_crc_calc;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic b);
        crc_step = (crc[CRC_W-1] ^ b) ? ((crc << 1) ^ CRC_POLY) : (crc << 1);
    endfunction

    // The sck register doubles as the half-period phase inside SHIFT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            tx_crc      <= '0;
            rx_sr       <= '0;
            rx_crc_sr   <= '0;
            rx_crc_calc <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_data     <= '0;
            rx_crc      <= '0;
            crc_err     <= 1'b0;
            sck         <= 1'b0;
            csn         <= 1'b1;
            mosi        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LEAD;
                        busy        <= 1'b1;
                        csn         <= 1'b0;
                        mosi        <= tx_data[DATA_W-1];
                        tx_sr       <= tx_data[DATA_W-2:0];
                        tx_crc      <= CRC_INIT;
                        rx_crc_calc <= CRC_INIT;
                        div_cnt     <= '0;
                    end
                end
                S_LEAD: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= S_SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sck     <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (sck) begin
                            // Falling edge: sample miso, fold the sent data bit into the tx CRC.
                            sck <= 1'b0;
                            if (bit_cnt <= LAST_DATA) begin
                                tx_crc      <= crc_step(tx_crc, mosi);
                                rx_sr       <= {rx_sr[DATA_W-2:0], miso};
                                rx_crc_calc <= crc_step(rx_crc_calc, miso);
                            end else begin
                                rx_crc_sr   <= {rx_crc_sr[CRC_W-2:0], miso};
                            end
                        end else if (bit_cnt == LAST_BIT) begin
                            state <= S_TRAIL;
                        end else begin
                            sck     <= 1'b1;
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt < LAST_DATA) begin
                                mosi  <= tx_sr[DATA_W-2];
                                tx_sr <= {tx_sr[DATA_W-3:0], 1'b0};
                            end else begin
                                mosi   <= tx_crc[CRC_W-1];
                                tx_crc <= {tx_crc[CRC_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_TRAIL: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= S_GAP;
                        div_cnt <= '0;
                        csn     <= 1'b1;
                        mosi    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        rx_crc  <= rx_crc_sr;
                        crc_err <= (rx_crc_sr != rx_crc_calc);
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= S_IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_crc.sv
// Bench for spi_master_crc: three instances (CLK_DIV 1, 2, 4) with loopback, bit-31
// corruption and a behavioural slave on miso, checked against a long-division CRC model.
module tb_spi_master_crc;

    typedef struct {
        int          idx;
        logic [23:0] tx;
        int          md;
        logic [23:0] sd;
        logic [23:0] exp_rx;
        logic [7:0]  exp_crc;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  miso_v;
    logic [23:0] tx_v [3];
    wire  [2:0]  busy_v, done_v, crc_err_v, sck_v, csn_v, mosi_v;
    wire  [23:0] rx_v [3];
    wire  [7:0]  rxc_v [3];

    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    int          mode [3];
    logic [23:0] slave_data [3];
    int          rises [3], falls [3], bad [3], frames [3], dones [3], hi_cnt [3], gap_last [3];
    logic [31:0] mrx [3], sframe [3];
    logic [2:0]  slave_bit = '0;
    logic [2:0]  prev_sck = '0;
    logic [2:0]  prev_csn = '1;

    spi_master_crc #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rstn(rstn), .start(start_v[0]), .tx_data(tx_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .rx_data(rx_v[0]), .rx_crc(rxc_v[0]), .crc_err(crc_err_v[0]),
        .sck(sck_v[0]), .csn(csn_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]));
    spi_master_crc #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rstn(rstn), .start(start_v[1]), .tx_data(tx_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .rx_data(rx_v[1]), .rx_crc(rxc_v[1]), .crc_err(crc_err_v[1]),
        .sck(sck_v[1]), .csn(csn_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]));
    spi_master_crc #(.CLK_DIV(4)) u_d4 (
        .clk(clk), .rstn(rstn), .start(start_v[2]), .tx_data(tx_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .rx_data(rx_v[2]), .rx_crc(rxc_v[2]), .crc_err(crc_err_v[2]),
        .sck(sck_v[2]), .csn(csn_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int div_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    // CRC as polynomial long division of the seeded, zero-augmented message by x^8+0x1D.
    function automatic logic [7:0] crc_ref(input logic [23:0] d);
        logic [31:0] m;
        m = {d ^ 24'hFF0000, 8'h00};
        for (int i = 31; i >= 8; i--)
            if (m[i]) m = m ^ (32'h11D << (i - 8));
        return m[7:0];
    endfunction

    // miso source per instance: 0 loopback, 1 loopback with bit 31 inverted, 2 slave model.
    always_comb begin
        miso_v = '0;
        for (int i = 0; i < 3; i++) begin
            case (mode[i])
                0:       miso_v[i] = mosi_v[i];
                1:       miso_v[i] = mosi_v[i] ^ (rises[i] == 32);
                default: miso_v[i] = slave_bit[i];
            endcase
        end
    end

    // Bus monitor and slave model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn) begin
                prev_sck[i] <= 1'b0;
                prev_csn[i] <= 1'b1;
            end else begin
                if (done_v[i]) dones[i] <= dones[i] + 1;
                if (prev_csn[i] && !csn_v[i]) begin
                    frames[i]   <= frames[i] + 1;
                    gap_last[i] <= hi_cnt[i];
                    rises[i]    <= 0;
                    falls[i]    <= 0;
                    mrx[i]      <= '0;
                    sframe[i]   <= {slave_data[i], crc_ref(slave_data[i])};
                end
                hi_cnt[i] <= csn_v[i] ? hi_cnt[i] + 1 : 0;
                if (sck_v[i] != prev_sck[i]) begin
                    if (csn_v[i]) begin
                        bad[i] <= bad[i] + 1;
                    end else if (sck_v[i]) begin
                        if (rises[i] < 32) slave_bit[i] <= sframe[i][31 - rises[i]];
                        rises[i] <= rises[i] + 1;
                    end else begin
                        mrx[i]   <= {mrx[i][30:0], mosi_v[i]};
                        falls[i] <= falls[i] + 1;
                    end
                end
                prev_sck[i] <= sck_v[i];
                prev_csn[i] <= csn_v[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic waitDone(input int idx, output int when);
        int n;
        n = 0;
        while (!done_v[idx] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done seen", {31'b0, done_v[idx]}, 1);
        when = cyc;
    endtask

    task automatic applyStimulus(input int idx, input logic [23:0] tx, input int md,
                                 input logic [23:0] sd, output int lat);
        int t0, t1;
        repeat (6) @(negedge clk);
        mode[idx]       = md;
        slave_data[idx] = sd;
        tx_v[idx]       = tx;
        start_v[idx]    = 1'b1;
        t0              = cyc;
        @(negedge clk);
        start_v[idx] = 1'b0;
        checkOutput("busy after start", {31'b0, busy_v[idx]}, 1);
        waitDone(idx, t1);
        lat = t1 - t0;
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v.idx, v.tx, v.md, v.sd, lat);
        checkOutput("rx_data", {8'b0, rx_v[v.idx]}, {8'b0, v.exp_rx});
        checkOutput("rx_crc", {24'b0, rxc_v[v.idx]}, {24'b0, v.exp_crc});
        checkOutput("crc_err", {31'b0, crc_err_v[v.idx]}, {31'b0, v.exp_err});
        checkOutput("done latency", lat, v.exp_lat);
        checkOutput("sck rises", rises[v.idx], 32);
        checkOutput("sck falls", falls[v.idx], 32);
        checkOutput("sck edges with csn high", bad[v.idx], 0);
        checkOutput("mosi stream", mrx[v.idx], {v.tx, crc_ref(v.tx)});
        if (v.md == 2)
            checkOutput("slave crc pass", {31'b0, mrx[v.idx][7:0] == crc_ref(mrx[v.idx][31:8])}, 1);
    endtask

    vec_t vecs [5];

    initial begin
        int   d0, f0, t_done, t_busy, n, lat;
        vec_t rv;

        vecs[0] = '{1, 24'h000000, 0, 24'h0, 24'h000000, 8'h0E, 1'b0, 133};
        vecs[1] = '{0, 24'hA5A5A5, 0, 24'h0, 24'hA5A5A5, crc_ref(24'hA5A5A5), 1'b0, 67};
        vecs[2] = '{2, 24'hA5A5A5, 0, 24'h0, 24'hA5A5A5, crc_ref(24'hA5A5A5), 1'b0, 265};
        vecs[3] = '{1, 24'h000000, 1, 24'h0, 24'h000000, 8'h0F, 1'b1, 133};
        vecs[4] = '{1, 24'h123456, 2, 24'hFEDCBA, 24'hFEDCBA, crc_ref(24'hFEDCBA), 1'b0, 133};

        for (int i = 0; i < 3; i++) begin
            tx_v[i] = '0; mode[i] = 0; slave_data[i] = '0;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset csn", {31'b0, csn_v[1]}, 1);
        checkOutput("reset sck", {31'b0, sck_v[1]}, 0);
        checkOutput("reset mosi", {31'b0, mosi_v[1]}, 0);
        checkOutput("reset busy", {31'b0, busy_v[1]}, 0);
        checkOutput("reset done", {31'b0, done_v[1]}, 0);
        checkOutput("reset rx_data", {8'b0, rx_v[1]}, 0);
        checkOutput("reset rx_crc", {24'b0, rxc_v[1]}, 0);
        checkOutput("reset crc_err", {31'b0, crc_err_v[1]}, 0);
        rstn = 1'b1;

        $display("[TB] directed vectors");
        for (int k = 0; k < 5; k++) runVector(vecs[k]);

        $display("[TB] start held high across frames");
        repeat (6) @(negedge clk);
        mode[1] = 0;
        tx_v[1] = 24'hA5A5A5;
        f0 = frames[1];
        start_v[1] = 1'b1;
        @(negedge clk);
        tx_v[1] = 24'h123456;
        waitDone(1, t_done);
        checkOutput("held start rx_data", {8'b0, rx_v[1]}, 32'hA5A5A5);
        checkOutput("held start frames", frames[1] - f0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy_v[1] && n < 50);
        t_busy = cyc;
        start_v[1] = 1'b0;
        checkOutput("restart spacing", t_busy - t_done, 3);
        waitDone(1, t_done);
        checkOutput("second frame rx_data", {8'b0, rx_v[1]}, 32'h123456);
        checkOutput("second frame crc_err", {31'b0, crc_err_v[1]}, 0);
        checkOutput("held start frames total", frames[1] - f0, 2);
        checkOutput("csn gap at least CLK_DIV", {31'b0, gap_last[1] >= 2}, 1);

        $display("[TB] reset during SHIFT");
        repeat (6) @(negedge clk);
        mode[1] = 0;
        tx_v[1] = 24'h3C3C3C;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        n = 0;
        while (rises[1] != 11 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bit10 reached", rises[1], 11);
        d0 = dones[1];
        rstn = 1'b0;
        #1;
        checkOutput("abort csn", {31'b0, csn_v[1]}, 1);
        checkOutput("abort sck", {31'b0, sck_v[1]}, 0);
        checkOutput("abort mosi", {31'b0, mosi_v[1]}, 0);
        checkOutput("abort busy", {31'b0, busy_v[1]}, 0);
        repeat (3) @(negedge clk);
        checkOutput("abort done low", {31'b0, done_v[1]}, 0);
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("no done after abort", dones[1] - d0, 0);
        runVector('{1, 24'h3C3C3C, 0, 24'h0, 24'h3C3C3C, crc_ref(24'h3C3C3C), 1'b0, 133});

        $display("[TB] random frames");
        for (int r = 0; r < 12; r++) begin
            rv.idx     = $urandom_range(0, 2);
            rv.md      = ($urandom_range(0, 1) == 1) ? 2 : 0;
            rv.tx      = 24'($urandom);
            rv.sd      = 24'($urandom);
            rv.exp_rx  = (rv.md == 2) ? rv.sd : rv.tx;
            rv.exp_crc = crc_ref(rv.exp_rx);
            rv.exp_err = 1'b0;
            rv.exp_lat = 1 + 66 * div_of(rv.idx);
            runVector(rv);
        end

        lat = 0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
